// File: rtl/sdwr_frame_ctrl.sv
// Write-side frame engine: drains the camera write FIFO into one SDRAM bank as
// fixed-length bursts, counts bursts per frame and flags frame completion.
module sdwr_frame_ctrl #(
    parameter int BURST_LEN    = 256,
    parameter int FRAME_BURSTS = 1200,
    parameter int OFFSET_W     = 20,
    parameter int USEDW_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_load,
    input  logic [1:0]            wr_bank,
    input  logic [USEDW_W-1:0]    fifo_usedw,
    input  logic                  sdram_wr_ack,
    input  logic                  sdram_wr_done,
    output logic                  sdram_wr_req,
    output logic [OFFSET_W+1:0]   sdram_wr_addr,
    output logic                  bank_valid,
    output logic                  frame_write_done
);

    localparam int CNT_W = $clog2(FRAME_BURSTS + 1);
    localparam logic [USEDW_W:0]    THRESH     = (USEDW_W + 1)'(BURST_LEN);
    localparam logic [OFFSET_W-1:0] BURST_STEP = OFFSET_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]    LAST_CNT   = CNT_W'(FRAME_BURSTS - 1);

    typedef enum logic [2:0] {IDLE, CHECK, REQ, BURST, NEXT, DONE} state_t;

    state_t                state_reg, state_next;
    logic                  req_reg, req_next;
    logic                  bank_valid_reg, bank_valid_next;
    logic                  frame_done_reg, frame_done_next;
    logic [1:0]            bank_lat_reg, bank_lat_next;
    logic [1:0]            bank_pend_reg, bank_pend_next;
    logic                  load_pend_reg, load_pend_next;
    logic [OFFSET_W-1:0]   offset_reg, offset_next;
    logic [CNT_W-1:0]      burst_cnt_reg, burst_cnt_next;
    logic [OFFSET_W+1:0]   addr_reg, addr_next;

    logic fifo_ready;
    logic last_burst;
    logic frame_start;

    assign fifo_ready  = {1'b0, fifo_usedw} >= THRESH;
    assign last_burst  = burst_cnt_reg == LAST_CNT;
    // A load is only honoured immediately outside an in-flight burst.
    assign frame_start = wr_load && (state_reg == IDLE || state_reg == CHECK ||
                                     state_reg == NEXT || state_reg == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            req_reg        <= 1'b0;
            bank_valid_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            bank_lat_reg   <= 2'b00;
            bank_pend_reg  <= 2'b00;
            load_pend_reg  <= 1'b0;
            offset_reg     <= '0;
            burst_cnt_reg  <= '0;
            addr_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            req_reg        <= req_next;
            bank_valid_reg <= bank_valid_next;
            frame_done_reg <= frame_done_next;
            bank_lat_reg   <= bank_lat_next;
            bank_pend_reg  <= bank_pend_next;
            load_pend_reg  <= load_pend_next;
            offset_reg     <= offset_next;
            burst_cnt_reg  <= burst_cnt_next;
            addr_reg       <= addr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:  if (wr_load) state_next = CHECK;
            CHECK: begin
                if (wr_load)         state_next = CHECK;
                else if (fifo_ready) state_next = REQ;
            end
            REQ:   if (sdram_wr_ack)  state_next = BURST;
            BURST: if (sdram_wr_done) state_next = NEXT;
            NEXT: begin
                if (wr_load || load_pend_reg) state_next = CHECK;
                else if (last_burst)          state_next = DONE;
                else                          state_next = CHECK;
            end
            DONE:  if (wr_load) state_next = CHECK;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bank_valid_next = bank_valid_reg;
        frame_done_next = frame_done_reg;
        bank_lat_next   = bank_lat_reg;
        bank_pend_next  = bank_pend_reg;
        load_pend_next  = load_pend_reg;
        offset_next     = offset_reg;
        burst_cnt_next  = burst_cnt_reg;

        if (frame_start) begin
            bank_lat_next   = wr_bank;
            offset_next     = '0;
            burst_cnt_next  = '0;
            bank_valid_next = 1'b1;
            frame_done_next = 1'b0;
            load_pend_next  = 1'b0;
        end else begin
            case (state_reg)
                REQ, BURST: begin
                    if (wr_load) begin
                        load_pend_next = 1'b1;
                        bank_pend_next = wr_bank;
                    end
                end
                NEXT: begin
                    if (load_pend_reg) begin
                        // Deferred restart: the old frame is abandoned without a done flag.
                        bank_lat_next  = bank_pend_reg;
                        offset_next    = '0;
                        burst_cnt_next = '0;
                        load_pend_next = 1'b0;
                    end else begin
                        offset_next    = offset_reg + BURST_STEP;
                        burst_cnt_next = burst_cnt_reg + 1'b1;
                        if (last_burst) begin
                            bank_valid_next = 1'b0;
                            frame_done_next = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        req_next  = (state_next == REQ);
        addr_next = {bank_lat_next, offset_next};
    end

    assign sdram_wr_req     = req_reg;
    assign sdram_wr_addr    = addr_reg;
    assign bank_valid       = bank_valid_reg;
    assign frame_write_done = frame_done_reg;

endmodule

// File: tb/tb_sdwr_frame_ctrl.sv
// Directed, table-driven bench for sdwr_frame_ctrl with a small frame
// (4-word bursts, 3 bursts per frame, 8-bit offsets).
module tb_sdwr_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_load = 1'b0;
    logic [1:0] wr_bank = 2'b00;
    logic [9:0] fifo_usedw = 10'd0;
    logic       sdram_wr_ack = 1'b0;
    logic       sdram_wr_done = 1'b0;
    logic       sdram_wr_req;
    logic [9:0] sdram_wr_addr;
    logic       bank_valid;
    logic       frame_write_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       load;
        logic [1:0] bank;
        logic [9:0] usedw;
        logic       ack;
        logic       done;
        logic       req;
        logic [9:0] addr;
        logic       bv;
        logic       fwd;
    } vec_t;

    vec_t vecs[$];

    sdwr_frame_ctrl #(
        .BURST_LEN(4),
        .FRAME_BURSTS(3),
        .OFFSET_W(8),
        .USEDW_W(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_load(wr_load),
        .wr_bank(wr_bank),
        .fifo_usedw(fifo_usedw),
        .sdram_wr_ack(sdram_wr_ack),
        .sdram_wr_done(sdram_wr_done),
        .sdram_wr_req(sdram_wr_req),
        .sdram_wr_addr(sdram_wr_addr),
        .bank_valid(bank_valid),
        .frame_write_done(frame_write_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic ld, input logic [1:0] bk, input int uw, input logic ak,
                       input logic dn, input logic rq, input int ad, input logic bv,
                       input logic fd);
        vec_t v;
        v.load = ld; v.bank = bk; v.usedw = 10'(uw); v.ack = ak; v.done = dn;
        v.req = rq; v.addr = 10'(ad); v.bv = bv; v.fwd = fd;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input logic rq, input logic [9:0] ad,
                                 input logic bv, input logic fd);
        check({tag, " req"},  32'(sdram_wr_req), 32'(rq));
        check({tag, " addr"}, 32'(sdram_wr_addr), 32'(ad));
        check({tag, " bank_valid"}, 32'(bank_valid), 32'(bv));
        check({tag, " frame_done"}, 32'(frame_write_done), 32'(fd));
    endtask

    initial begin
        //   ld  bank  usedw ack done | req addr   bv fwd
        add(0, 2'b00, 8, 0, 0,   0, 'h000, 0, 0);  // 0 idle, no load
        add(1, 2'b01, 8, 0, 0,   0, 'h100, 1, 0);  // 1 load bank 1
        add(0, 2'b00, 8, 0, 0,   1, 'h100, 1, 0);  // 2 req two edges after load
        add(0, 2'b00, 8, 0, 0,   1, 'h100, 1, 0);  // 3 req held until ack
        add(0, 2'b00, 8, 1, 0,   0, 'h100, 1, 0);  // 4 ack clears req
        add(0, 2'b00, 8, 0, 0,   0, 'h100, 1, 0);  // 5 burst running
        add(0, 2'b00, 8, 0, 1,   0, 'h100, 1, 0);  // 6 done -> NEXT
        add(0, 2'b00, 8, 0, 0,   0, 'h104, 1, 0);  // 7 offset advanced
        add(0, 2'b00, 8, 0, 0,   1, 'h104, 1, 0);  // 8 second req
        add(0, 2'b00, 8, 1, 1,   0, 'h104, 1, 0);  // 9 ack+done together = ack only
        add(0, 2'b00, 8, 0, 0,   0, 'h104, 1, 0);  // 10 still in burst
        add(0, 2'b00, 8, 0, 1,   0, 'h104, 1, 0);  // 11 real done
        add(0, 2'b00, 8, 0, 0,   0, 'h108, 1, 0);  // 12
        add(0, 2'b00, 8, 0, 0,   1, 'h108, 1, 0);  // 13 third req
        add(0, 2'b00, 8, 1, 0,   0, 'h108, 1, 0);  // 14
        add(0, 2'b00, 8, 0, 1,   0, 'h108, 1, 0);  // 15 last done
        add(0, 2'b00, 8, 0, 0,   0, 'h10C, 0, 1);  // 16 frame complete
        add(0, 2'b00, 8, 0, 1,   0, 'h10C, 0, 1);  // 17 stray done ignored
        add(0, 2'b00, 8, 1, 0,   0, 'h10C, 0, 1);  // 18 stray ack ignored
        add(1, 2'b11, 8, 0, 0,   0, 'h300, 1, 0);  // 19 load in DONE
        add(0, 2'b00, 3, 0, 0,   0, 'h300, 1, 0);  // 20 fifo below threshold
        add(0, 2'b00, 3, 0, 0,   0, 'h300, 1, 0);  // 21
        add(0, 2'b00, 3, 0, 0,   0, 'h300, 1, 0);  // 22
        add(0, 2'b00, 3, 0, 0,   0, 'h300, 1, 0);  // 23
        add(0, 2'b00, 4, 0, 0,   1, 'h300, 1, 0);  // 24 threshold reached
        add(0, 2'b00, 8, 1, 0,   0, 'h300, 1, 0);  // 25
        add(0, 2'b00, 8, 0, 1,   0, 'h300, 1, 0);  // 26
        add(0, 2'b00, 8, 0, 0,   0, 'h304, 1, 0);  // 27
        add(0, 2'b00, 8, 0, 0,   1, 'h304, 1, 0);  // 28 burst 1 req
        add(0, 2'b00, 8, 1, 0,   0, 'h304, 1, 0);  // 29
        add(1, 2'b10, 8, 0, 0,   0, 'h304, 1, 0);  // 30 load mid-burst
        add(0, 2'b00, 8, 0, 0,   0, 'h304, 1, 0);  // 31 no req before done
        add(0, 2'b00, 8, 0, 1,   0, 'h304, 1, 0);  // 32
        add(0, 2'b00, 8, 0, 0,   0, 'h200, 1, 0);  // 33 pending load applied
        add(0, 2'b00, 8, 0, 0,   1, 'h200, 1, 0);  // 34
        add(0, 2'b00, 8, 1, 0,   0, 'h200, 1, 0);  // 35
        add(0, 2'b00, 8, 0, 1,   0, 'h200, 1, 0);  // 36
        add(0, 2'b00, 8, 0, 0,   0, 'h204, 1, 0);  // 37 counters restarted
        add(0, 2'b00, 8, 0, 0,   1, 'h204, 1, 0);  // 38 req for reset test

        // Reset behaviour
        #2 rst_n = 1'b0;
        #1 check_outputs("reset", 1'b0, 10'h000, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            wr_load       = vecs[i].load;
            wr_bank       = vecs[i].bank;
            fifo_usedw    = vecs[i].usedw;
            sdram_wr_ack  = vecs[i].ack;
            sdram_wr_done = vecs[i].done;
            @(posedge clk); #1;
            $display("vec %0d: load=%0b bank=%0d usedw=%0d ack=%0b done=%0b -> req=%0b addr=0x%03h bv=%0b fwd=%0b",
                     i, vecs[i].load, vecs[i].bank, vecs[i].usedw, vecs[i].ack, vecs[i].done,
                     sdram_wr_req, sdram_wr_addr, bank_valid, frame_write_done);
            check_outputs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr,
                          vecs[i].bv, vecs[i].fwd);
        end
        wr_load = 1'b0; sdram_wr_ack = 1'b0; sdram_wr_done = 1'b0;

        // Asynchronous reset while req is high clears outputs without a clock edge
        #2 rst_n = 1'b0;
        #1 check_outputs("async_rst", 1'b0, 10'h000, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            $display("post-reset cycle %0d: req=%0b bv=%0b", c, sdram_wr_req, bank_valid);
            check($sformatf("post_rst%0d req", c), 32'(sdram_wr_req), 32'd0);
            check($sformatf("post_rst%0d bank_valid", c), 32'(bank_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
